// File: rtl/sp_ram_pkg.sv
// Shared definitions for the single-port RAM controller: FSM state encoding
// and default word/address widths.
// The INIT state only exists when SP_RAM_CTRL_INIT_EN is defined.
package sp_ram_pkg;

  localparam int DATA_DEFAULT = 4;
  localparam int ADDR_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_CAP,
    RESP
`ifdef SP_RAM_CTRL_INIT_EN
    , INIT
`endif
  } state_e;

endpackage

// File: rtl/sp_ram_ctrl.sv
// Request/response front end for an external single-port RAM that has a
// registered read port. Each write takes one strobe cycle. Each read takes one
// strobe cycle and one capture cycle, then waits for rsp_ready.
// All RAM-facing and handshake outputs come straight from flops.
// Optional feature: define SP_RAM_CTRL_INIT_EN to zero-fill the whole RAM
// after every reset before the first request is accepted.
module sp_ram_ctrl
  import sp_ram_pkg::*;
#(
  parameter int DATA = DATA_DEFAULT,
  parameter int ADDR = ADDR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [ADDR-1:0] req_addr,
  input  logic [DATA-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DATA-1:0] rsp_rdata,
  output logic            ram_we,
  output logic            ram_re,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_wdata,
  input  logic [DATA-1:0] ram_rdata
);

`ifdef SP_RAM_CTRL_INIT_EN
  // Reset goes through the zero-fill sequence, so requests are held off.
  localparam state_e          RESET_STATE = INIT;
  localparam logic            RESET_READY = 1'b0;
  localparam logic [ADDR-1:0] ADDR_LAST   = {ADDR{1'b1}};
`else
  localparam state_e          RESET_STATE = IDLE;
  localparam logic            RESET_READY = 1'b1;
`endif

  state_e          state_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic [DATA-1:0] rsp_rdata_q;
  logic            ram_we_q;
  logic            ram_re_q;
  logic [ADDR-1:0] ram_addr_q;
  logic [DATA-1:0] ram_wdata_q;
`ifdef SP_RAM_CTRL_INIT_EN
  logic [ADDR-1:0] init_addr_q;  // next address to clear
  logic            init_wait_q;  // 1 = the clear strobe is in flight
`endif

  // Controller FSM: the state and every registered output are updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      req_ready_q <= RESET_READY;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
`ifdef SP_RAM_CTRL_INIT_EN
      init_addr_q <= '0;
      init_wait_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            ram_addr_q  <= req_addr;
            if (req_we) begin
              ram_we_q    <= 1'b1;
              ram_wdata_q <= req_wdata;
              state_q     <= WR;
            end else begin
              ram_re_q <= 1'b1;
              state_q  <= RD;
            end
          end
        end

        // The RAM commits the write on this edge; the strobe was one cycle wide.
        WR: begin
          ram_we_q    <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end

        // The RAM samples the read on this edge; its data appears next cycle.
        RD: begin
          ram_re_q <= 1'b0;
          state_q  <= RD_CAP;
        end

        RD_CAP: begin
          rsp_rdata_q <= ram_rdata;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end

        // Hold the response until it is taken. req_ready rises only afterwards,
        // so a request cannot be accepted on the handshake edge.
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

`ifdef SP_RAM_CTRL_INIT_EN
        // Alternate strobe and gap cycles.
        // The address advances on the gap edge.
        INIT: begin
          if (!init_wait_q) begin
            ram_we_q    <= 1'b1;
            ram_addr_q  <= init_addr_q;
            ram_wdata_q <= '0;
            init_wait_q <= 1'b1;
          end else begin
            ram_we_q    <= 1'b0;
            init_wait_q <= 1'b0;
            if (init_addr_q == ADDR_LAST) begin
              req_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              init_addr_q <= init_addr_q + ADDR'(1);
            end
          end
        end
`endif

        default: begin
          ram_we_q    <= 1'b0;
          ram_re_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed bench for sp_ram_ctrl.
// It includes a behavioural single-port RAM with a registered read port.
// Define SP_RAM_CTRL_INIT_EN here as well as in the RTL to exercise the
// zero-fill path.
module tb_sp_ram_ctrl;

  localparam int DATA = 4;
  localparam int ADDR = 2;

`ifdef SP_RAM_CTRL_INIT_EN
  localparam logic RST_READY = 1'b0;
`else
  localparam logic RST_READY = 1'b1;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [ADDR-1:0] req_addr = '0;
  logic [DATA-1:0] req_wdata = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [DATA-1:0] rsp_rdata;
  logic            ram_we;
  logic            ram_re;
  logic [ADDR-1:0] ram_addr;
  logic [DATA-1:0] ram_wdata;
  logic [DATA-1:0] ram_rdata = '0;

  logic [DATA-1:0] mem [0:(1<<ADDR)-1];

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int re_cnt   = 0;
  int both_cnt = 0;
  logic [ADDR+DATA-1:0] wr_log [$];

  always #5 clk = ~clk;

  sp_ram_ctrl #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // External RAM: write on strobe; read data is registered and held between reads.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  // Strobe monitor: pulse counts, overlap count and a log of every write.
  always @(posedge clk) begin
    if (ram_we) begin
      we_cnt <= we_cnt + 1;
      wr_log.push_back({ram_addr, ram_wdata});
    end
    if (ram_re) re_cnt <= re_cnt + 1;
    if (ram_we && ram_re) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, req_ready}, {31'd0, RST_READY});
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 0);
    check({tag, "_rsp_rdata"}, {28'd0, rsp_rdata}, 0);
    check({tag, "_ram_we"}, {31'd0, ram_we}, 0);
    check({tag, "_ram_re"}, {31'd0, ram_re}, 0);
    check({tag, "_ram_addr"}, {30'd0, ram_addr}, 0);
    check({tag, "_ram_wdata"}, {28'd0, ram_wdata}, 0);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (req_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("wait_ready_timeout", {31'd0, req_ready}, 1);
  endtask

  task automatic do_write(input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
    check("wr_ready_pre", {31'd0, req_ready}, 1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick();
    check("wr_we", {31'd0, ram_we}, 1);
    check("wr_re", {31'd0, ram_re}, 0);
    check("wr_addr", {30'd0, ram_addr}, {30'd0, a});
    check("wr_data", {28'd0, ram_wdata}, {28'd0, d});
    check("wr_ready_busy", {31'd0, req_ready}, 0);
    req_valid = 1'b0; req_we = 1'b0; req_addr = ~a; req_wdata = ~d;
    tick();
    check("wr_we_drop", {31'd0, ram_we}, 0);
    check("wr_ready_back", {31'd0, req_ready}, 1);
    $display("write addr=%0d data=0x%0h", a, d);
  endtask

  // hold = number of cycles rsp_valid must be observed with rsp_ready low (0 = taken at once)
  task automatic do_read(input logic [ADDR-1:0] a, input logic [DATA-1:0] exp, input int hold);
    check("rd_ready_pre", {31'd0, req_ready}, 1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    rsp_ready = (hold == 0);
    tick();
    check("rd_re", {31'd0, ram_re}, 1);
    check("rd_we", {31'd0, ram_we}, 0);
    check("rd_addr", {30'd0, ram_addr}, {30'd0, a});
    check("rd_ready_busy", {31'd0, req_ready}, 0);
    req_valid = 1'b0; req_we = 1'b1; req_addr = ~a;
    tick();
    check("rd_re_drop", {31'd0, ram_re}, 0);
    check("rd_valid_early", {31'd0, rsp_valid}, 0);
    tick();
    check("rd_valid", {31'd0, rsp_valid}, 1);
    check("rd_data", {28'd0, rsp_rdata}, {28'd0, exp});
    if (hold > 0) begin
      // A competing write sits on the request port while the response waits.
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = 4'hF;
      for (int i = 1; i < hold; i++) begin
        tick();
        check("hold_valid", {31'd0, rsp_valid}, 1);
        check("hold_data", {28'd0, rsp_rdata}, {28'd0, exp});
        check("hold_ready", {31'd0, req_ready}, 0);
        check("hold_we", {31'd0, ram_we}, 0);
        check("hold_re", {31'd0, ram_re}, 0);
      end
      rsp_ready = 1'b1;
    end
    tick();
    check("rsp_done_valid", {31'd0, rsp_valid}, 0);
    check("rsp_done_ready", {31'd0, req_ready}, 1);
    check("rsp_done_we", {31'd0, ram_we}, 0);
    req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
    $display("read  addr=%0d data=0x%0h hold=%0d", a, exp, hold);
  endtask

  initial begin
    int w0;
    int r0;
    logic [DATA-1:0] exp_after_rst;

    // Reset: create a real falling edge, then check outputs asynchronously and while held.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    tick();
    tick();
    check_reset_outputs("rst_hold");
    wr_log.delete();
    rst_n = 1'b1;

`ifdef SP_RAM_CTRL_INIT_EN
    wait_ready(40);
    check("init_write_count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_log.size()) check("init_write_entry", {26'd0, wr_log[i]}, {26'd0, 2'(i), 4'h0});
    end
    $display("init done, %0d zero-writes", wr_log.size());
    do_read(2'd3, 4'h0, 0);
    exp_after_rst = 4'h0;
`else
    tick();
    check("post_rst_we", {31'd0, ram_we}, 0);
    check("post_rst_re", {31'd0, ram_re}, 0);
    check("post_rst_ready", {31'd0, req_ready}, 1);
    exp_after_rst = 4'h4;
`endif

    // Write then read one location with the response taken immediately.
    w0 = we_cnt; r0 = re_cnt;
    do_write(2'd2, 4'hA);
    do_read(2'd2, 4'hA, 0);
    check("single_we_pulses", we_cnt - w0, 1);
    check("single_re_pulses", re_cnt - r0, 1);

    // Fill every address, then read back out of order.
    for (int i = 0; i < 4; i++) do_write(2'(i), 4'(i + 1));
    do_read(2'd3, 4'h4, 0);
    do_read(2'd0, 4'h1, 0);

    // Back-pressured response held for 5 cycles.
    w0 = we_cnt; r0 = re_cnt;
    do_read(2'd1, 4'h2, 5);
    check("hold_we_pulses", we_cnt - w0, 0);
    check("hold_re_pulses", re_cnt - r0, 1);

    // Reset while the read data is being captured.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd1;
    tick();
    req_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_rdcap");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rdcap_no_rsp", {31'd0, rsp_valid}, 0);
    end
    $display("reset during read capture");
    rsp_ready = 1'b1;
    wait_ready(40);
    do_read(2'd3, exp_after_rst, 0);

    check("strobe_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sp_ram_ctrl.md
SP_RAM_CTRL -- requirements
Module: sp_ram_ctrl

Interface
REQ-001 Parameter DATA, default 4, data word width in bits.
REQ-002 Parameter ADDR, default 2, address width; RAM depth is 2**ADDR words.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low (one clock; the polarity and synchronicity are fixed).
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR  request address.
REQ-009 req_wdata  input  DATA  write data.
REQ-010 rsp_valid  output  1  read data present.
REQ-011 rsp_ready  input  1  consumer accepts read data.
REQ-012 rsp_rdata  output  DATA  read data.
REQ-013 ram_we  output  1  RAM write strobe, registered.
REQ-014 ram_re  output  1  RAM read strobe, registered.
REQ-015 ram_addr  output  ADDR  RAM address, registered.
REQ-016 ram_wdata  output  DATA  RAM write data, registered.
REQ-017 ram_rdata  input  DATA  RAM read data; it is registered inside the RAM and is valid on the cycle after the edge that sampled ram_re.

Function
REQ-018 The FSM SHALL have states IDLE, WR, RD, RD_CAP and RESP; INIT is added under REQ-031.
REQ-019 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on an edge where req_valid and req_ready are both 1.
REQ-020 On a write accept at edge T: ram_we=1, ram_addr=req_addr and ram_wdata=req_wdata SHALL be registered, and the state SHALL go to WR.
  - The RAM writes at T+1; the controller then drops ram_we and returns to IDLE.
  - req_ready SHALL be 1 again after T+1, giving a write throughput of one per 2 cycles.
REQ-021 On a read accept at edge T: ram_re=1 and ram_addr=req_addr SHALL be registered, and the state SHALL go to RD.
  - At T+1, ram_re drops and the state goes to RD_CAP.
  - At T+2, ram_rdata is captured into rsp_rdata, rsp_valid goes to 1 and the state goes to RESP.
REQ-022 In RESP, rsp_valid and rsp_rdata SHALL hold stable until an edge where rsp_ready=1, after which rsp_valid=0 and the state returns to IDLE.
REQ-023 No request SHALL be accepted in the same cycle as a response handshake.
REQ-024 ram_we and ram_re SHALL never both be 1, and each SHALL be high for exactly one cycle per operation.
REQ-025 req_* inputs SHALL be ignored outside the accept edge; the registered copies are used.
REQ-026 Addresses SHALL be used unmodified; there is no wrap logic beyond ADDR bits.
REQ-027 rsp_ready asserted while rsp_valid=0 SHALL have no effect.

Reset
REQ-028 While rst_n=0, state=IDLE and every output SHALL be 0, except req_ready, which SHALL be 1 (0 when INIT is compiled in).
REQ-029 Reset asserted mid-operation SHALL abort it and drop ram_we/ram_re immediately; any pending response SHALL be discarded.
REQ-030 No RAM strobe SHALL be asserted in the first cycle after rst_n deasserts, unless INIT is compiled in.

Configuration
REQ-031 Macro SP_RAM_CTRL_INIT_EN:
  - When defined, reset SHALL enter INIT. INIT writes 0 to addresses 0 .. 2**ADDR-1 in ascending order, using a one-cycle ram_we pulse every 2 cycles, with req_ready=0 throughout, then enters IDLE.
  - Reset during INIT SHALL restart INIT from address 0.
  - When the macro is undefined, reset enters IDLE and the RAM contents are undefined.

Structure
REQ-032 A shared package sp_ram_pkg SHALL hold the FSM state enum and the default DATA/ADDR constants.
REQ-033 No sub-module SHALL be used. The controller connects externally to the existing single-port RAM: ram_* to we/re/addr/data_in, and ram_rdata from data_out.

Verification
REQ-034 Write addr 2, data 0xA, then read addr 2 with rsp_ready=1 -> one ram_we pulse, one ram_re pulse, rsp_valid for 1 cycle with rsp_rdata=0xA, two cycles after the read accept.
REQ-035 Write addresses 0..3 with data 0x1..0x4, then read back 3,0 -> 0x4 then 0x1; req_ready low during each operation.
REQ-036 Read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable for 5 cycles, req_ready=0, no RAM strobes; the handshake then returns to IDLE.
REQ-037 Assert rst_n=0 in the RD_CAP cycle -> all outputs 0 at once, no rsp_valid after release.
REQ-038 With SP_RAM_CTRL_INIT_EN, reset then read addr 3 -> exactly 4 zero-writes to addresses 0,1,2,3 before req_ready=1, and rsp_rdata=0x0.
